// File: rtl/ctrl_multiciclo_if.sv
// Shared instruction/data memory port between the multicycle controller
// and the memory. The controller masters the request; memory answers ready.
interface ctrl_multiciclo_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM for an RV32I subset (ADD/SUB/AND/OR, ANDI, LH, SH, BNE).
// Moore controls are registered from the next state so an async reset clears
// them immediately; ir_write/pc_write/pc_branch are Mealy on registered state.
module ctrl_multiciclo #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_zero,
  ctrl_multiciclo_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR_LD, S_ADDR_ST,
    S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_TRAP
  } state_t;

  state_t             r_state;
  logic [TMO_W-1:0]   r_tmo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_req, r_mem_we, r_addr_sel;
  logic               r_alu_src_b, r_reg_write, r_wb_sel;
  logic [1:0]         r_alu_op;
  logic               r_illegal, r_bus_err;

  state_t w_nxt;
  logic   w_in_mem, w_acc, w_tmo, w_ill, w_retire;

  // Next state, acceptance/timeout decisions and retire strobe
  always_comb begin
    w_nxt    = r_state;
    w_in_mem = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    w_acc    = 1'b0;
    w_tmo    = 1'b0;
    w_ill    = 1'b0;
    w_retire = 1'b0;
    // Acceptance wins over a timeout reached in the same cycle
    if (w_in_mem) begin
      if (mem.mem_ready)         w_acc = 1'b1;
      else if (r_tmo == TMO_LAST) w_tmo = 1'b1;
    end
    case (r_state)
      S_RESET:   w_nxt = S_FETCH;
      S_FETCH:   if (w_acc) w_nxt = S_DECODE;
      S_DECODE: begin
        w_nxt = S_TRAP;
        case (opcode)
          7'b0110011: if (funct3 == 3'b000 ||
                          ((funct3 == 3'b111 || funct3 == 3'b110) && !funct7_5))
                        w_nxt = S_EXEC_R;
          7'b0010011: if (funct3 == 3'b111) w_nxt = S_EXEC_I;
          7'b0000011: if (funct3 == 3'b001) w_nxt = S_ADDR_LD;
          7'b0100011: if (funct3 == 3'b001) w_nxt = S_ADDR_ST;
          7'b1100011: if (funct3 == 3'b001) w_nxt = S_BRANCH;
          default:    w_nxt = S_TRAP;
        endcase
        w_ill = (w_nxt == S_TRAP);
      end
      S_EXEC_R, S_EXEC_I: w_nxt = S_WB_ALU;
      S_ADDR_LD: w_nxt = S_MEM_RD;
      S_ADDR_ST: w_nxt = S_MEM_WR;
      S_MEM_RD:  if (w_acc) w_nxt = S_WB_MEM;
      S_MEM_WR:  if (w_acc) begin w_nxt = S_FETCH; w_retire = 1'b1; end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin w_nxt = S_FETCH; w_retire = 1'b1; end
      S_TRAP:    w_nxt = S_TRAP;
      default:   w_nxt = S_TRAP;
    endcase
    if (w_tmo) w_nxt = S_TRAP;
  end

  // State, wait counter, retire counter, sticky flags and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET;
      r_tmo       <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_addr_sel  <= 1'b0;
      r_alu_src_b <= 1'b0;
      r_alu_op    <= 2'b00;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_illegal   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_acc || w_nxt != r_state)         r_tmo <= '0;
      else if (w_in_mem && !mem.mem_ready)   r_tmo <= r_tmo + 1'b1;
      if (w_retire) r_cnt     <= r_cnt + 1'b1;
      if (w_ill)    r_illegal <= 1'b1;
      if (w_tmo)    r_bus_err <= 1'b1;

      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_addr_sel  <= 1'b0;
      r_alu_src_b <= 1'b0;
      r_alu_op    <= 2'b00;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 1'b0;
      case (w_nxt)
        S_FETCH:   r_mem_req <= 1'b1;
        S_EXEC_R:  r_alu_op <= 2'b10;
        S_EXEC_I:  begin r_alu_src_b <= 1'b1; r_alu_op <= 2'b10; end
        S_ADDR_LD, S_ADDR_ST: r_alu_src_b <= 1'b1;
        S_MEM_RD:  begin r_mem_req <= 1'b1; r_addr_sel <= 1'b1; end
        S_MEM_WR:  begin r_mem_req <= 1'b1; r_addr_sel <= 1'b1; r_mem_we <= 1'b1; end
        S_WB_ALU:  r_reg_write <= 1'b1;
        S_WB_MEM:  begin r_reg_write <= 1'b1; r_wb_sel <= 1'b1; end
        S_BRANCH:  r_alu_op <= 2'b01;
        default:   ;
      endcase
    end
  end

  assign mem.mem_req      = r_mem_req;
  assign mem.mem_we       = r_mem_we;
  assign mem.mem_addr_sel = r_addr_sel;
  assign ir_write    = (r_state == S_FETCH) && mem.mem_ready;
  assign pc_write    = (r_state == S_FETCH) && mem.mem_ready;
  assign pc_branch   = (r_state == S_BRANCH) && !alu_zero;
  assign alu_src_b   = r_alu_src_b;
  assign alu_op      = r_alu_op;
  assign reg_write   = r_reg_write;
  assign wb_sel      = r_wb_sel;
  assign illegal     = r_illegal;
  assign bus_err     = r_bus_err;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Directed bench for ctrl_multiciclo: a per-cycle vector table for a short
// program, plus hand sequences for trap hold, timeout and reset corners.
module tb_ctrl_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic        alu_zero = 1'b0;
  logic        ir_write, pc_write, pc_branch, alu_src_b, reg_write, wb_sel, illegal, bus_err;
  logic [1:0]  alu_op;
  logic [31:0] instr_count;

  ctrl_multiciclo_if bus();

  ctrl_multiciclo #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem(bus.master), .ir_write(ir_write), .pc_write(pc_write),
    .pc_branch(pc_branch), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Control word: {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_branch,
  //                alu_src_b, alu_op[1:0], reg_write, wb_sel, illegal, bus_err}
  localparam logic [12:0] C_IDLE = 13'h0000, C_FW = 13'h1000, C_FA = 13'h1300,
                          C_EXI = 13'h0060, C_EXR = 13'h0020, C_WBA = 13'h0008,
                          C_ADR = 13'h0040, C_MRD = 13'h1400, C_MWR = 13'h1C00,
                          C_WBM = 13'h000C, C_BRT = 13'h0090, C_BRN = 13'h0010,
                          C_ILL = 13'h0002, C_BUS = 13'h0001;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23,
                         OP_BR = 7'h63, OP_LUI = 7'h37;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [12:0] exp;
    logic [31:0] cnt;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[35];

  function automatic vec_t mkv(logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                               logic rdy, logic [12:0] exp, logic [31:0] cnt);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = exp; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [12:0] ctl();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_write, pc_write, pc_branch,
            alu_src_b, alu_op, reg_write, wb_sel, illegal, bus_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check just after
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; alu_zero = v.z; bus.mem_ready = v.rdy;
    #1;
    chk({nm, ".ctl"}, {19'd0, ctl()}, {19'd0, v.exp});
    chk({nm, ".cnt"}, instr_count, v.cnt);
  endtask

  // Pulse reset; checks outputs during reset and right after release (RESET state)
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk({nm, ".rst_ctl"}, {19'd0, ctl()}, 32'd0);
    chk({nm, ".rst_cnt"}, instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({nm, ".rel_ctl"}, {19'd0, ctl()}, 32'd0);
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    // ANDI x1,x1,0xFF (0x0FF0F093), zero-wait
    tbl[0]  = mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b1, C_FA,  32'd0);
    tbl[1]  = mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b1, C_IDLE, 32'd0);
    tbl[2]  = mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b1, C_EXI, 32'd0);
    tbl[3]  = mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b1, C_WBA, 32'd0);
    // LH with three wait cycles in MEM_RD
    tbl[4]  = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b1, C_FA,  32'd1);
    tbl[5]  = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b1, C_IDLE, 32'd1);
    tbl[6]  = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b1, C_ADR, 32'd1);
    tbl[7]  = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b0, C_MRD, 32'd1);
    tbl[8]  = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b0, C_MRD, 32'd1);
    tbl[9]  = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b0, C_MRD, 32'd1);
    tbl[10] = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b1, C_MRD, 32'd1);
    tbl[11] = mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b1, C_WBM, 32'd1);
    // BNE taken
    tbl[12] = mkv(OP_BR, 3'b001, 1'b0, 1'b0, 1'b1, C_FA,  32'd2);
    tbl[13] = mkv(OP_BR, 3'b001, 1'b0, 1'b0, 1'b1, C_IDLE, 32'd2);
    tbl[14] = mkv(OP_BR, 3'b001, 1'b0, 1'b0, 1'b1, C_BRT, 32'd2);
    // BNE not taken
    tbl[15] = mkv(OP_BR, 3'b001, 1'b0, 1'b1, 1'b1, C_FA,  32'd3);
    tbl[16] = mkv(OP_BR, 3'b001, 1'b0, 1'b1, 1'b1, C_IDLE, 32'd3);
    tbl[17] = mkv(OP_BR, 3'b001, 1'b0, 1'b1, 1'b1, C_BRN, 32'd3);
    // SH then ADD; FETCH after MEM_WR waits one cycle with we/addr_sel low
    tbl[18] = mkv(OP_ST, 3'b001, 1'b0, 1'b0, 1'b1, C_FA,  32'd4);
    tbl[19] = mkv(OP_ST, 3'b001, 1'b0, 1'b0, 1'b1, C_IDLE, 32'd4);
    tbl[20] = mkv(OP_ST, 3'b001, 1'b0, 1'b0, 1'b1, C_ADR, 32'd4);
    tbl[21] = mkv(OP_ST, 3'b001, 1'b0, 1'b0, 1'b1, C_MWR, 32'd4);
    tbl[22] = mkv(OP_R,  3'b000, 1'b0, 1'b0, 1'b0, C_FW,  32'd5);
    tbl[23] = mkv(OP_R,  3'b000, 1'b0, 1'b0, 1'b1, C_FA,  32'd5);
    tbl[24] = mkv(OP_R,  3'b000, 1'b0, 1'b0, 1'b1, C_IDLE, 32'd5);
    tbl[25] = mkv(OP_R,  3'b000, 1'b0, 1'b0, 1'b1, C_EXR, 32'd5);
    tbl[26] = mkv(OP_R,  3'b000, 1'b0, 1'b0, 1'b1, C_WBA, 32'd5);
    // SUB
    tbl[27] = mkv(OP_R,  3'b000, 1'b1, 1'b0, 1'b1, C_FA,  32'd6);
    tbl[28] = mkv(OP_R,  3'b000, 1'b1, 1'b0, 1'b1, C_IDLE, 32'd6);
    tbl[29] = mkv(OP_R,  3'b000, 1'b1, 1'b0, 1'b1, C_EXR, 32'd6);
    tbl[30] = mkv(OP_R,  3'b000, 1'b1, 1'b0, 1'b1, C_WBA, 32'd6);
    // LUI is unsupported
    tbl[31] = mkv(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, C_FA,  32'd7);
    tbl[32] = mkv(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, C_IDLE, 32'd7);
    tbl[33] = mkv(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, C_ILL, 32'd7);
    tbl[34] = mkv(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, C_ILL, 32'd7);

    repeat (2) @(negedge clk);
    do_reset("init");
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // TRAP holds with all controls low, even with ready/branch inputs toggling
    for (int i = 0; i < 20; i++)
      run_vec(mkv(OP_BR, 3'b001, 1'b0, i[0], i[1], C_ILL, 32'd7), $sformatf("trap%0d", i));
    do_reset("trap_clr");

    // mem_ready never arrives in FETCH: 16 wait cycles then bus error
    for (int i = 0; i < 16; i++)
      run_vec(mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b0, C_FW, 32'd0), $sformatf("tmo_w%0d", i));
    run_vec(mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b1, C_BUS, 32'd0), "tmo_trap");
    run_vec(mkv(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, C_BUS, 32'd0), "tmo_hold");

    // ready on the 16th wait cycle is accepted
    do_reset("acc16");
    for (int i = 0; i < 15; i++)
      run_vec(mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b0, C_FW, 32'd0), $sformatf("acc_w%0d", i));
    run_vec(mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b1, C_FA, 32'd0), "acc_take");
    run_vec(mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd0), "acc_dec");
    run_vec(mkv(OP_I, 3'b111, 1'b0, 1'b0, 1'b0, C_EXI, 32'd0), "acc_exi");

    // Reset asserted mid-MEM_RD drops mem_req at once; late ready is ignored
    do_reset("midrd");
    run_vec(mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b1, C_FA,  32'd0), "mid_f");
    run_vec(mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd0), "mid_d");
    run_vec(mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b0, C_ADR, 32'd0), "mid_a");
    run_vec(mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b0, C_MRD, 32'd0), "mid_m");
    #1 rst_n = 1'b0;
    #1 chk("mid_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("mid_ctl", {19'd0, ctl()}, 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel", {19'd0, ctl()}, 32'd0);
    run_vec(mkv(OP_LD, 3'b001, 1'b0, 1'b0, 1'b0, C_FW, 32'd0), "mid_refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
